// File: rtl/keccak_perm_arbiter.sv
// keccak_perm_arbiter
// Shares one Keccak-f[1600] permutation core among NUM_REQ requesters.
// A round-robin grant captures the winner's state, the core is driven with
// a level start held until done, and the permuted state goes back to the
// granted requester over valid/ready. A watchdog turns a hung permutation
// into an error response so requesters never deadlock.
module keccak_perm_arbiter #(
    parameter  int NUM_REQ        = 3,
    parameter  int TIMEOUT_CYCLES = 255,
    localparam int ID_W           = $clog2(NUM_REQ),
    localparam int SW             = 1600
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*SW-1:0] req_state,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   rsp_valid,
    input  logic [NUM_REQ-1:0]   rsp_ready,
    output logic [SW-1:0]        rsp_state,
    output logic                 rsp_err,
    output logic                 perm_start,
    output logic [SW-1:0]        perm_state_o,
    input  logic                 perm_done,
    input  logic [SW-1:0]        perm_state_i,
    output logic                 busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    // Constants pre-sized to the vectors they are compared against.
    localparam logic [ID_W:0]   NUM_REQ_X = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_RST  = ID_W'(NUM_REQ - 1);
    localparam logic [WD_W-1:0] WD_LIMIT  = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     last_grant_q, last_grant_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic [SW-1:0]       op_q, op_d;
    logic [SW-1:0]       res_q, res_d;
    logic                rsp_err_q, rsp_err_d;
    logic                timeout_err_q, timeout_err_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic [WD_W-1:0]     wdog_inc;
    logic                perm_start_q;
    logic                busy_q;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;

    logic                win_found;
    logic [ID_W-1:0]     win_id;
    logic [ID_W:0]       cand;
    logic [SW-1:0]       win_state;

    // Round-robin search: first valid requester starting one past the last grant.
    always_comb begin
        // NOTE: every combinationally written signal gets a default before any
        // conditional assignment; otherwise a latch is inferred.
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, last_grant_q} + (ID_W+1)'(k + 1);
            if (cand >= NUM_REQ_X) begin
                cand = cand - NUM_REQ_X;
            end
            if (!win_found && req_valid[cand[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = cand[ID_W-1:0];
            end
        end
    end

    // Select the winning requester's state slice.
    always_comb begin
        win_state = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                win_state = req_state[i*SW +: SW];
            end
        end
    end

    // Acceptance is combinational and only offered while idle.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && win_found) begin
            req_ready[win_id] = 1'b1;
        end
    end

    // Next-state logic for the grant / run / respond sequence.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_id_d    = grant_id_q;
        op_d          = op_q;
        res_d         = res_q;
        rsp_err_d     = rsp_err_q;
        timeout_err_d = timeout_err_q;
        wdog_d        = wdog_q;
        // The incremented count includes the current RUN cycle, so the abort
        // response appears exactly TIMEOUT_CYCLES after the request handshake.
        wdog_inc      = wdog_q + WD_W'(1);

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d    = RUN;
                    grant_id_d = win_id;
                    op_d       = win_state;
                    wdog_d     = '0;
                end
            end

            RUN: begin
                wdog_d = wdog_inc;
                // Done has priority over an abort in the same cycle.
                if (perm_done) begin
                    res_d     = perm_state_i;
                    rsp_err_d = 1'b0;
                    state_d   = RESP;
                end else if (wdog_inc == WD_LIMIT) begin
                    res_d         = '0;
                    rsp_err_d     = 1'b1;
                    timeout_err_d = 1'b1;
                    state_d       = RESP;
                end
            end

            RESP: begin
                // Only the granted requester's ready matters.
                if (rsp_ready[grant_id_q]) begin
                    last_grant_d = grant_id_q;
                    state_d      = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // One-hot response valid aimed at the granted requester.
    always_comb begin
        rsp_valid_d = '0;
        if (state_d == RESP) begin
            rsp_valid_d[grant_id_d] = 1'b1;
        end
    end

    // State and output registers; outputs are registered copies of next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= LAST_RST;
            grant_id_q    <= '0;
            op_q          <= '0;
            res_q         <= '0;
            rsp_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            wdog_q        <= '0;
            perm_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            rsp_valid_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_id_q    <= grant_id_d;
            op_q          <= op_d;
            res_q         <= res_d;
            rsp_err_q     <= rsp_err_d;
            timeout_err_q <= timeout_err_d;
            wdog_q        <= wdog_d;
            perm_start_q  <= (state_d == RUN);
            busy_q        <= (state_d != IDLE);
            rsp_valid_q   <= rsp_valid_d;
        end
    end

    assign perm_start   = perm_start_q;
    assign perm_state_o = op_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_state    = res_q;
    assign rsp_err      = rsp_err_q;
    assign busy         = busy_q;
    assign grant_id     = grant_id_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_keccak_perm_arbiter.sv
// Scoreboard bench for keccak_perm_arbiter: stimulus pushes expected
// responses, a monitor pops and compares each response as it appears.
module tb_keccak_perm_arbiter;

    localparam int N  = 3;
    localparam int TC = 40;
    localparam int SW = 1600;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*SW-1:0] req_state;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [SW-1:0]   rsp_state;
    logic            rsp_err;
    logic            perm_start;
    logic [SW-1:0]   perm_state_o;
    logic            perm_done;
    logic [SW-1:0]   perm_state_i;
    logic            busy;
    logic [1:0]      grant_id;
    logic            timeout_err;

    keccak_perm_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TC)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_state    (req_state),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_state    (rsp_state),
        .rsp_err      (rsp_err),
        .perm_start   (perm_start),
        .perm_state_o (perm_state_o),
        .perm_done    (perm_done),
        .perm_state_i (perm_state_i),
        .busy         (busy),
        .grant_id     (grant_id),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got low64 0x%0h, expected low64 0x%0h", name, act[63:0], exp[63:0]);
        end
    endtask

    // Core model: done in the core_lat-th cycle of start, result = operand ^ mask.
    logic          core_en;
    int            core_lat;
    logic [SW-1:0] core_mask;
    int            run_cnt;

    initial begin
        perm_done = 1'b0;
        run_cnt   = 0;
        forever begin
            @(negedge clk);
            if (perm_start) run_cnt++;
            else            run_cnt = 0;
            perm_done = perm_start && core_en && (run_cnt == core_lat);
        end
    end

    assign perm_state_i = perm_done ? (perm_state_o ^ core_mask) : '0;

    // Scoreboard.
    typedef struct {
        logic [1:0]    id;
        logic [SW-1:0] st;
        logic          err;
    } exp_t;

    exp_t sb_q[$];

    task automatic push_exp(input logic [1:0] id, input logic [SW-1:0] st, input logic err);
        exp_t e;
        e.id  = id;
        e.st  = st;
        e.err = err;
        sb_q.push_back(e);
    endtask

    // Monitor: compare each new response against the oldest expectation.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_valid != '0 && !prev) begin
                check("sb_has_expected", 64'(sb_q.size() > 0), 64'(1));
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("rsp_valid_onehot", 64'(rsp_valid), 64'(1) << e.id);
                    check_state("rsp_state", rsp_state, e.st);
                    check("rsp_err", 64'(rsp_err), 64'(e.err));
                    check("rsp_grant_id", 64'(grant_id), 64'(e.id));
                end
            end
            prev = (rsp_valid != '0);
        end
    end

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Called shortly after a negedge; returns in the grant cycle (negedge + small delay).
    task automatic wait_grant(input string name, input logic [N-1:0] exp);
        int n;
        n = 0;
        #1;
        while (req_ready == '0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, 64'(req_ready), 64'(exp));
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(busy), 64'(0));
    endtask

    // Cycles from the first RUN cycle (n = 1) until rsp_valid appears.
    task automatic wait_rsp(output int n);
        n = 1;
        while (rsp_valid == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    logic [SW-1:0] exp_rr [N];

    initial begin
        int n;
        int cnt;
        int bad_rr;
        int hold_bad;

        rst       = 1'b1;
        req_valid = '0;
        req_state = '0;
        rsp_ready = '1;
        core_en   = 1'b1;
        core_lat  = 25;
        core_mask = '0;

        // Reset state.
        @(negedge clk);
        #1;
        check("rst_perm_start", 64'(perm_start), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_grant_id", 64'(grant_id), 64'(0));
        check("rst_rsp_err", 64'(rsp_err), 64'(0));
        check("rst_timeout_err", 64'(timeout_err), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check_state("rst_rsp_state", rsp_state, '0);
        check_state("rst_perm_state_o", perm_state_o, '0);
        rst = 1'b0;
        @(negedge clk);

        // Single request from requester 1; 0x1 ^ 0xABCC = 0xABCD.
        core_mask = 1600'hABCC;
        req_state[1*SW +: SW] = 1600'h1;
        req_valid = 3'b010;
        push_exp(2'd1, 1600'hABCD, 1'b0);
        wait_grant("single_req_ready", 3'b010);
        @(negedge clk);
        req_valid = '0;
        n = 0;
        cnt = 0;
        while (rsp_valid == '0 && n < 200) begin
            if (perm_start) cnt++;
            @(negedge clk);
            n++;
        end
        check("single_start_cycles", 64'(cnt), 64'(25));
        check("single_grant_id", 64'(grant_id), 64'(1));
        wait_idle("single_idle");

        // Round-robin with everyone valid from reset.
        do_reset();
        core_lat  = 6;
        core_mask = 1600'hF0F0;
        req_state[0*SW +: SW] = 1600'h1111;
        req_state[1*SW +: SW] = 1600'h2222;
        req_state[2*SW +: SW] = 1600'h3333;
        exp_rr[0] = 1600'hE1E1;
        exp_rr[1] = 1600'hD2D2;
        exp_rr[2] = 1600'hC3C3;
        req_valid = 3'b111;
        wait_grant("rr_first_grant", 3'b001);
        for (int g = 0; g < 6; g++) begin
            logic prev_ps;
            int   rises;
            int   low;
            int   m;
            push_exp(2'(g % 3), exp_rr[g % 3], 1'b0);
            prev_ps = 1'b0;
            rises   = 0;
            low     = 0;
            m       = 0;
            do begin
                @(negedge clk);
                #1;
                m++;
                if (perm_start && !prev_ps) rises++;
                if (!perm_start && rises > 0) low++;
                prev_ps = perm_start;
            end while (req_ready == '0 && m < 200);
            check("rr_start_edges", 64'(rises), 64'(1));
            check("rr_start_gap", 64'(low), 64'(2));
            check("rr_grant_order", 64'(req_ready), 64'(1) << ((g + 1) % 3));
        end
        req_valid = '0;
        wait_idle("rr_idle");

        // Backpressure on requester 2 while requester 0 waits.
        rsp_ready = 3'b011;
        req_state[2*SW +: SW] = 1600'h5A5A;
        @(negedge clk);
        req_valid = 3'b100;
        push_exp(2'd2, 1600'hAAAA, 1'b0);
        wait_grant("bp_grant2", 3'b100);
        @(negedge clk);
        req_valid = 3'b001;
        bad_rr = 0;
        n = 0;
        #1;
        while (rsp_valid == '0 && n < 200) begin
            if (req_ready != '0) bad_rr++;
            @(negedge clk);
            #1;
            n++;
        end
        check("bp_rsp_arrived", 64'(rsp_valid), 64'(3'b100));
        hold_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid != 3'b100 || rsp_state != 1600'hAAAA) hold_bad++;
            if (req_ready != '0) bad_rr++;
            @(negedge clk);
            #1;
        end
        if (rsp_valid != 3'b100 || rsp_state != 1600'hAAAA) hold_bad++;
        rsp_ready = 3'b111;
        #1;
        if (req_ready != '0) bad_rr++;
        check("bp_hold_stable", 64'(hold_bad), 64'(0));
        check("bp_req_ready_blocked", 64'(bad_rr), 64'(0));
        push_exp(2'd0, 1600'hE1E1, 1'b0);
        @(negedge clk);
        #1;
        check("bp_req_ready_after_rsp", 64'(req_ready), 64'(3'b001));
        @(negedge clk);
        req_valid = '0;
        wait_idle("bp_idle");

        // Watchdog: core never answers.
        core_en = 1'b0;
        req_state[1*SW +: SW] = 1600'h77;
        @(negedge clk);
        req_valid = 3'b010;
        push_exp(2'd1, '0, 1'b1);
        wait_grant("wd_grant1", 3'b010);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(n);
        check("wd_latency", 64'(n), 64'(TC));
        check("wd_timeout_err", 64'(timeout_err), 64'(1));
        wait_idle("wd_idle");
        core_en = 1'b1;
        @(negedge clk);
        req_valid = 3'b100;
        push_exp(2'd2, 1600'hAAAA, 1'b0);
        wait_grant("wd_next_grant2", 3'b100);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(n);
        wait_idle("wd_next_idle");
        check("wd_timeout_err_sticky", 64'(timeout_err), 64'(1));

        // Done on the watchdog's final cycle: done wins.
        do_reset();
        check("col_timeout_err_cleared", 64'(timeout_err), 64'(0));
        core_lat = TC - 1;
        req_state[0*SW +: SW] = 1600'h3;
        req_valid = 3'b001;
        push_exp(2'd0, 1600'hF0F3, 1'b0);
        wait_grant("col_grant0", 3'b001);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(n);
        check("col_latency", 64'(n), 64'(TC));
        check("col_timeout_err", 64'(timeout_err), 64'(0));
        wait_idle("col_idle");

        // Reset five cycles into RUN.
        core_lat = 25;
        req_state[0*SW +: SW] = 1600'h1111;
        @(negedge clk);
        req_valid = 3'b100;
        wait_grant("rm_grant2", 3'b100);
        @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);
        #1;
        check("rm_running", 64'(perm_start), 64'(1));
        check("rm_grant_before", 64'(grant_id), 64'(2));
        #1;
        rst = 1'b1;
        #1;
        check("rm_perm_start", 64'(perm_start), 64'(0));
        check("rm_busy", 64'(busy), 64'(0));
        check("rm_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rm_grant_id", 64'(grant_id), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        req_valid = 3'b111;
        push_exp(2'd0, 1600'hE1E1, 1'b0);
        wait_grant("rm_grant0_after_rst", 3'b001);
        @(negedge clk);
        req_valid = '0;
        wait_idle("rm_idle");

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, tests_run=%0d", tests_run);
        $fatal(1);
    end

endmodule
